// File: rtl/config_mem_loader.sv
// Neuron config-memory writer: unpacks a framed 32-bit word stream into mem A/B/C write strobes.
// Optional trailing XOR checksum word when CFG_CHECKSUM_EN is defined.
module config_mem_loader #(
  parameter int unsigned NUM_NURNS          = 256,
  parameter int unsigned NUM_AXONS          = 256,
  parameter int unsigned DSIZE              = 16,
  parameter int unsigned NURN_CNT_BIT_WIDTH = 8,
  parameter int unsigned AXON_CNT_BIT_WIDTH = 8,
  parameter int unsigned STDP_WIN_BIT_WIDTH = 8,
  parameter int unsigned AER_BIT_WIDTH      = 32,
  localparam int unsigned MEM_WIDTH_A = 2*STDP_WIN_BIT_WIDTH + 2*DSIZE + 1,
  localparam int unsigned MEM_WIDTH_B = 2 + 2*DSIZE + AER_BIT_WIDTH,
  localparam int unsigned ADDR_C_W    = NURN_CNT_BIT_WIDTH + AXON_CNT_BIT_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [AER_BIT_WIDTH-1:0]      cfgWord_i,
  input  logic                          cfgValid_i,
  output logic                          cfgReady_o,
  output logic                          wrEn_Config_A_o,
  output logic [NURN_CNT_BIT_WIDTH-1:0] Addr_Config_A_o,
  output logic [MEM_WIDTH_A-1:0]        wrData_A_o,
  output logic                          wrEn_Config_B_o,
  output logic [NURN_CNT_BIT_WIDTH-1:0] Addr_Config_B_o,
  output logic [MEM_WIDTH_B-1:0]        wrData_B_o,
  output logic                          wrEn_Config_C_o,
  output logic [ADDR_C_W-1:0]           Addr_Config_C_o,
  output logic                          wrData_C_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o
);

  localparam int unsigned W      = AER_BIT_WIDTH;
  localparam int unsigned WPE_A  = (MEM_WIDTH_A + W - 1) / W;
  localparam int unsigned WPE_B  = (MEM_WIDTH_B + W - 1) / W;
  localparam int unsigned ASM_W  = ((MEM_WIDTH_A > MEM_WIDTH_B) ? MEM_WIDTH_A : MEM_WIDTH_B) - W;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WCNT_W = 2;
  localparam int unsigned BIT_W  = $clog2(W);
  localparam int unsigned NA_W   = NURN_CNT_BIT_WIDTH;

  localparam logic [1:0] TGT_A    = 2'b00;
  localparam logic [1:0] TGT_B    = 2'b01;
  localparam logic [1:0] TGT_C    = 2'b10;
  localparam logic [1:0] TGT_RSVD = 2'b11;

  // Address widths must cover the core's neuron and axon populations.
  if (NUM_NURNS > (1 << NURN_CNT_BIT_WIDTH) || NUM_AXONS > (1 << AXON_CNT_BIT_WIDTH)) begin : g_param_chk
    $error("config_mem_loader: address width too small for NUM_NURNS/NUM_AXONS");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR1,
    S_COLLECT,
    S_WRITE
`ifdef CFG_CHECKSUM_EN
    , S_CHK
`endif
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              tgt_q, tgt_d;
  logic [CNT_W-1:0]        rem_q, rem_d;
  logic [ADDR_C_W-1:0]     addr_q, addr_d;
  logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic                    last_q, last_d;
  logic [ASM_W-1:0]        asm_q, asm_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    wr_a_q, wr_a_d, wr_b_q, wr_b_d, wr_c_q, wr_c_d;
  logic [NA_W-1:0]         addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [ADDR_C_W-1:0]     addr_c_q, addr_c_d;
  logic [MEM_WIDTH_A-1:0]  data_a_q, data_a_d;
  logic [MEM_WIDTH_B-1:0]  data_b_q, data_b_d;
  logic                    data_c_q, data_c_d;
`ifdef CFG_CHECKSUM_EN
  logic [W-1:0]            xor_q, xor_d;
`endif

  logic         xfer;
  logic         emit;
  logic         last_word;
  logic         c_bit;
  logic [W-1:0] c_word;

  assign xfer      = cfgValid_i & ready_q;
  assign c_word    = asm_q[W-1:0];
  assign c_bit     = (state_q == S_WRITE) ? c_word[bit_q] : cfgWord_i[0];
  assign last_word = (tgt_q == TGT_A) ? (wcnt_q == WCNT_W'(WPE_A - 1))
                                      : (wcnt_q == WCNT_W'(WPE_B - 1));

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    rem_d    = rem_q;
    addr_d   = addr_q;
    wcnt_d   = wcnt_q;
    bit_d    = bit_q;
    last_d   = last_q;
    asm_d    = asm_q;
    done_d   = 1'b0;
    err_d    = err_q;
    wr_a_d   = 1'b0;
    wr_b_d   = 1'b0;
    wr_c_d   = 1'b0;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    addr_c_d = addr_c_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    data_c_d = data_c_q;
    emit     = 1'b0;
`ifdef CFG_CHECKSUM_EN
    xor_d    = xor_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          if (cfgWord_i[W-1:W-2] == TGT_RSVD) begin
            err_d = 1'b1;
          end else begin
            tgt_d   = cfgWord_i[W-1:W-2];
            rem_d   = cfgWord_i[CNT_W-1:0];
            state_d = S_HDR1;
`ifdef CFG_CHECKSUM_EN
            xor_d   = cfgWord_i;
`endif
          end
        end
      end
      S_HDR1: begin
        if (xfer) begin
          addr_d  = cfgWord_i[ADDR_C_W-1:0];
          wcnt_d  = '0;
          bit_d   = '0;
          last_d  = 1'b0;
          state_d = S_COLLECT;
`ifdef CFG_CHECKSUM_EN
          xor_d   = xor_q ^ cfgWord_i;
`endif
        end
      end
      S_COLLECT: begin
        if (xfer) begin
          asm_d = {asm_q[ASM_W-W-1:0], cfgWord_i};
`ifdef CFG_CHECKSUM_EN
          xor_d = xor_q ^ cfgWord_i;
`endif
          if (tgt_q == TGT_C) begin
            emit    = 1'b1;
            bit_d   = BIT_W'(1);
            state_d = S_WRITE;
          end else if (last_word) begin
            emit    = 1'b1;
            wcnt_d  = '0;
            state_d = S_WRITE;
          end else begin
            wcnt_d  = wcnt_q + WCNT_W'(1);
          end
        end
      end
      S_WRITE: begin
        // bit_q wraps to 0 once bit W-1 of a C word has been issued.
        if (last_q) begin
`ifdef CFG_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_IDLE;
          done_d  = 1'b1;
`endif
        end else if (tgt_q == TGT_C && bit_q != '0) begin
          emit  = 1'b1;
          bit_d = bit_q + BIT_W'(1);
        end else begin
          state_d = S_COLLECT;
        end
      end
`ifdef CFG_CHECKSUM_EN
      S_CHK: begin
        if (xfer) begin
          if (cfgWord_i != xor_q) err_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // One entry leaves per emit; address wraps by truncation.
    if (emit) begin
      last_d = (rem_q == '0);
      rem_d  = rem_q - CNT_W'(1);
      addr_d = addr_q + ADDR_C_W'(1);
      case (tgt_q)
        TGT_A: begin
          wr_a_d   = 1'b1;
          addr_a_d = addr_q[NA_W-1:0];
          data_a_d = {asm_q[MEM_WIDTH_A-W-1:0], cfgWord_i};
        end
        TGT_B: begin
          wr_b_d   = 1'b1;
          addr_b_d = addr_q[NA_W-1:0];
          data_b_d = {asm_q[MEM_WIDTH_B-W-1:0], cfgWord_i};
        end
        default: begin
          wr_c_d   = 1'b1;
          addr_c_d = addr_q;
          data_c_d = c_bit;
        end
      endcase
    end

    ready_d = (state_d != S_WRITE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      tgt_q    <= '0;
      rem_q    <= '0;
      addr_q   <= '0;
      wcnt_q   <= '0;
      bit_q    <= '0;
      last_q   <= 1'b0;
      asm_q    <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wr_a_q   <= 1'b0;
      wr_b_q   <= 1'b0;
      wr_c_q   <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      addr_c_q <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
      data_c_q <= 1'b0;
`ifdef CFG_CHECKSUM_EN
      xor_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      rem_q    <= rem_d;
      addr_q   <= addr_d;
      wcnt_q   <= wcnt_d;
      bit_q    <= bit_d;
      last_q   <= last_d;
      asm_q    <= asm_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      wr_a_q   <= wr_a_d;
      wr_b_q   <= wr_b_d;
      wr_c_q   <= wr_c_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      addr_c_q <= addr_c_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      data_c_q <= data_c_d;
`ifdef CFG_CHECKSUM_EN
      xor_q    <= xor_d;
`endif
    end
  end

  assign cfgReady_o      = ready_q;
  assign wrEn_Config_A_o = wr_a_q;
  assign Addr_Config_A_o = addr_a_q;
  assign wrData_A_o      = data_a_q;
  assign wrEn_Config_B_o = wr_b_q;
  assign Addr_Config_B_o = addr_b_q;
  assign wrData_B_o      = data_b_q;
  assign wrEn_Config_C_o = wr_c_q;
  assign Addr_Config_C_o = addr_c_q;
  assign wrData_C_o      = data_c_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_config_mem_loader.sv
// Bench for config_mem_loader: frame-level model of expected writes checked against every strobe.
module tb_config_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cfgWord = '0;
  logic        cfgValid = 1'b0;
  logic        cfgReady;
  logic        wrEn_A, wrEn_B, wrEn_C;
  logic [7:0]  Addr_A, Addr_B;
  logic [15:0] Addr_C;
  logic [48:0] wrData_A;
  logic [65:0] wrData_B;
  logic        wrData_C;
  logic        busy, done, err;

  config_mem_loader dut (
    .clk_i(clk), .rst_n_i(rst_n), .cfgWord_i(cfgWord), .cfgValid_i(cfgValid),
    .cfgReady_o(cfgReady),
    .wrEn_Config_A_o(wrEn_A), .Addr_Config_A_o(Addr_A), .wrData_A_o(wrData_A),
    .wrEn_Config_B_o(wrEn_B), .Addr_Config_B_o(Addr_B), .wrData_B_o(wrData_B),
    .wrEn_Config_C_o(wrEn_C), .Addr_Config_C_o(Addr_C), .wrData_C_o(wrData_C),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  port;
    logic [15:0] addr;
    logic [95:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] pl[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          done_seen = 0;
  int          strobe_cnt = 0;
  int          cyc = 0;
  int          strobe_cyc = 0;
  int          done_cyc = 0;
  int          last_xfer_cyc = 0;
  int          pay_cyc = 0;
  bit          err_exp = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entry e of the current payload: A/B MS-word-first, truncated to memory width; C one bit each.
  function automatic logic [95:0] model_data(input int tgt, input int e);
    logic [95:0] acc;
    logic [31:0] w;
    int          wpe;
    int          mw;
    acc = '0;
    if (tgt == 2) begin
      w = pl[e / 32];
      return {95'b0, w[e % 32]};
    end
    wpe = (tgt == 0) ? 2 : 3;
    mw  = (tgt == 0) ? 49 : 66;
    for (int k = 0; k < wpe; k++) acc = (acc << 32) | {64'b0, pl[e * wpe + k]};
    return acc & ((96'd1 << mw) - 96'd1);
  endfunction

  function automatic logic [15:0] model_addr(input int tgt, input int start, input int e);
    int a;
    a = (tgt == 2) ? ((start + e) % 65536) : ((start + e) % 256);
    return 16'(a);
  endfunction

  task automatic push_exp(input int tgt, input int start, input int n);
    for (int e = 0; e < n; e++)
      exp_q.push_back('{2'(tgt), model_addr(tgt, start, e), model_data(tgt, e)});
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Every strobe cycle is compared with the head of the expected-write queue.
  int          ns;
  wr_t         e_w;
  logic [1:0]  a_port;
  logic [15:0] a_addr;
  logic [95:0] a_data;
  always @(negedge clk) begin
    if (rst_n) begin
      ns = int'(wrEn_A) + int'(wrEn_B) + int'(wrEn_C);
      if (ns != 0) begin
        strobe_cnt++;
        strobe_cyc = cyc;
        chk("strobe_onehot", ns, 1);
        chk("ready_low_in_write", cfgReady, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", ns, 0);
        end else begin
          e_w = exp_q.pop_front();
          if (wrEn_A) begin
            a_port = 2'd0; a_addr = {8'b0, Addr_A}; a_data = {47'b0, wrData_A};
          end else if (wrEn_B) begin
            a_port = 2'd1; a_addr = {8'b0, Addr_B}; a_data = {30'b0, wrData_B};
          end else begin
            a_port = 2'd2; a_addr = Addr_C; a_data = {95'b0, wrData_C};
          end
          chk("wr_port", a_port, e_w.port);
          chk("wr_addr", a_addr, e_w.addr);
          chk("wr_data", a_data, e_w.data);
        end
      end
      if (done) begin
        done_seen++;
        done_cyc = cyc;
        chk("busy_low_with_done", busy, 0);
      end
    end
  end

  task automatic send(input logic [31:0] w, input int gap_max);
    int k;
    int t;
    k = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (k) begin
      @(negedge clk);
      cfgValid = 1'b0;
    end
    @(negedge clk);
    cfgWord  = w;
    cfgValid = 1'b1;
    t = 0;
    while (!cfgReady && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("ready_timeout", cfgReady, 1);
    last_xfer_cyc = cyc;
  endtask

  task automatic run_frame(input int tgt, input int cnt_m1, input int start, input int gap_max,
                           input bit bad_chk);
    logic [31:0] h0, h1, x;
    int d0;
    int t;
    h0 = {2'(tgt), 14'b0, 16'(cnt_m1)};
    h1 = {16'b0, 16'(start)};
    push_exp(tgt, start, cnt_m1 + 1);
    d0 = done_seen;
    send(h0, gap_max);
    send(h1, gap_max);
    x = h0 ^ h1;
    foreach (pl[i]) begin
      send(pl[i], gap_max);
      x = x ^ pl[i];
    end
    pay_cyc = last_xfer_cyc;
    x = x ^ {31'b0, bad_chk};
`ifdef CFG_CHECKSUM_EN
    err_exp = err_exp | bad_chk;
    send(x, gap_max);
`endif
    @(negedge clk);
    cfgValid = 1'b0;
    t = 0;
    while (done_seen == d0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("done_pulse", done_seen, d0 + 1);
    chk("writes_drained", exp_q.size(), 0);
    chk("err_state", err, err_exp);
    chk("busy_idle", busy, 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", cfgReady, 1);
    chk("rst_wren", {wrEn_A, wrEn_B, wrEn_C}, 0);
    chk("rst_addr", {Addr_A, Addr_B, Addr_C}, 0);
    chk("rst_data", {wrData_A, wrData_B, wrData_C}, 0);
    chk("rst_status", {busy, done, err}, 0);
  endtask

  initial begin
    int s0;
    int t;
    @(negedge clk);
    chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;

    // Pin the model against hand-computed packings.
    pl = '{32'h0001_2345, 32'h6789_ABCD};
    chk("pin_a", model_data(0, 0), 96'h1_2345_6789_ABCD);
    pl = '{32'hFFFE_0001, 32'h6789_ABCD};
    chk("pin_a_excess", model_data(0, 0), 96'h0_0001_6789_ABCD);
    pl = '{32'hFFFF_FFFD, 32'h1111_1111, 32'h2222_2222};
    chk("pin_b", model_data(1, 0), 96'h1_1111_1111_2222_2222);
    chk("pin_b_wrap", model_addr(1, 16'hFE, 2), 16'h0000);
    pl = '{32'hFFFF_0000, 32'h0000_00A5};
    chk("pin_c15", model_data(2, 15), 0);
    chk("pin_c16", model_data(2, 16), 1);
    chk("pin_c33", model_data(2, 33), 0);
    chk("pin_c39", model_data(2, 39), 1);
    chk("pin_c_addr", model_addr(2, 16'h0100, 39), 16'h0127);

    // Single A entry at address 5.
    pl = '{32'h0001_2345, 32'h6789_ABCD};
    s0 = strobe_cnt;
    run_frame(0, 0, 5, 0, 1'b0);
    chk("a_strobes", strobe_cnt - s0, 1);
    chk("a_wr_latency", strobe_cyc - pay_cyc, 1);
`ifdef CFG_CHECKSUM_EN
    chk("a_done_latency", done_cyc - last_xfer_cyc, 1);
`else
    chk("a_done_latency", done_cyc - strobe_cyc, 1);
`endif

    // B burst across the address wrap.
    pl = '{32'hFFFF_FFFD, 32'h1111_1111, 32'h2222_2222,
           32'h0000_0002, 32'hDEAD_BEEF, 32'h0BAD_F00D,
           32'h0000_0003, 32'h1234_5678, 32'h9ABC_DEF0};
    s0 = strobe_cnt;
    run_frame(1, 2, 16'hFE, 0, 1'b0);
    chk("b_strobes", strobe_cnt - s0, 3);

    // C unpack, 40 bits over two words.
    pl = '{32'hFFFF_0000, 32'h0000_00A5};
    s0 = strobe_cnt;
    run_frame(2, 39, 16'h0100, 0, 1'b0);
    chk("c_strobes", strobe_cnt - s0, 40);

    // Same B burst with random valid gaps.
    pl = '{32'hFFFF_FFFD, 32'h1111_1111, 32'h2222_2222,
           32'h0000_0002, 32'hDEAD_BEEF, 32'h0BAD_F00D,
           32'h0000_0003, 32'h1234_5678, 32'h9ABC_DEF0};
    s0 = strobe_cnt;
    run_frame(1, 2, 16'hFE, 3, 1'b0);
    chk("b_gap_strobes", strobe_cnt - s0, 3);

    // C with gaps, then an A pair with a correct trailer.
    pl = '{32'h8000_0001, 32'h5555_AAAA};
    run_frame(2, 63, 16'hFFF0, 2, 1'b0);
    pl = '{32'h0000_7FFF, 32'h0000_0000, 32'h0001_0000, 32'hFFFF_FFFF};
    run_frame(0, 1, 16'h80, 0, 1'b0);

`ifdef CFG_CHECKSUM_EN
    // Wrong trailer: writes still happen, err set, done pulses.
    pl = '{32'h0000_0001, 32'hCAFE_F00D, 32'h1357_9BDF};
    s0 = strobe_cnt;
    run_frame(1, 0, 16'h33, 0, 1'b1);
    chk("badchk_strobes", strobe_cnt - s0, 1);
`endif

    // Reset after the first of three B entries.
    pl = '{32'h0000_0001, 32'hAAAA_0000, 32'h0000_BBBB,
           32'h0000_0002, 32'h1111_2222, 32'h3333_4444,
           32'h0000_0003, 32'h5555_6666, 32'h7777_8888};
    exp_q.push_back('{2'd1, model_addr(1, 16'h10, 0), model_data(1, 0)});
    send({2'b01, 14'b0, 16'd2}, 0);
    send(32'h0000_0010, 0);
    for (int i = 0; i < 3; i++) send(pl[i], 0);
    @(negedge clk);
    cfgValid = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("rst_first_entry", exp_q.size(), 0);
    @(negedge clk);
    rst_n = 1'b0;
    err_exp = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    s0 = strobe_cnt;
    repeat (10) @(negedge clk);
    chk("rst_no_strobes", strobe_cnt - s0, 0);
    chk("rst_idle_ready", cfgReady, 1);

    // Reserved target: sticky error, no writes, next frame still processed.
    s0 = done_seen;
    send({2'b11, 14'b0, 16'd4}, 0);
    @(negedge clk);
    cfgValid = 1'b0;
    err_exp = 1'b1;
    @(negedge clk);
    chk("rsvd_err", err, 1);
    chk("rsvd_busy", busy, 0);
    repeat (4) @(negedge clk);
    chk("rsvd_no_done", done_seen, s0);
    pl = '{32'h0000_0F0F};
    s0 = strobe_cnt;
    run_frame(2, 7, 16'h0200, 0, 1'b0);
    chk("after_rsvd_strobes", strobe_cnt - s0, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
